// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Register file for the pipelined CPU datapath with a per-register scoreboard.
// Decode/issue reads operands through two asynchronous read ports and claims a
// destination register. Claiming sets its busy bit so later instructions stall
// on RAW/WAW hazards. Writeback stores the result and clears the busy bit.
//
// Parameters:
//   DATA_W   - data word width in bits
//   ADDR_W   - register address width; depth is 2**ADDR_W
//   ZERO_REG - 1: register 0 reads 0, ignores writes and is never busy
//
// Ports:
//   clk, rst             - clock; synchronous active-high reset
//   rd_addr1/2           - read addresses (rs / rt)
//   rd_data1/2           - combinational read data
//   rd_busy1/2           - addressed register has a pending write
//   claim_valid/addr     - issue requests ownership of a destination register
//   claim_ready          - claim is accepted this cycle (depends on state only)
//   wr_en/addr/data      - writeback; stores data and releases the register
//   busy_cnt             - registered count of busy registers
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   When defined, a writeback in flight is forwarded to a read port with a
//   matching address in the same cycle (data = wr_data, busy = 0 unless rst).
//   When undefined, reads show the stored state and new data appears the
//   cycle after the write edge.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              claim_valid,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              claim_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic wr_take;
    logic claim_take;

    // True when the address names the hardwired-zero register.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Claim acceptance looks only at registered busy state, so a writeback in
    // the same cycle can never combinationally enable a claim.
    assign claim_ready = is_zero(claim_addr) || !busy_q[claim_addr];

    assign wr_take    = wr_en && !is_zero(wr_addr);
    assign claim_take = claim_valid && claim_ready && !is_zero(claim_addr);

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can leave a latch behind.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_take) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        // Applied after the write so that a same-cycle claim on a free
        // register wins over the release.
        if (claim_take) begin
            busy_d[claim_addr] = 1'b1;
        end

        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    // NOTE: the register array is reset on purpose: after reset every register
    // must read 0, which a reset-free RAM could not guarantee.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Read port 1
    always_comb begin
        rd_data1 = regs_q[rd_addr1];
        rd_busy1 = busy_q[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            if (!rst) begin
                rd_busy1 = 1'b0;
            end
        end
`endif
        if (is_zero(rd_addr1)) begin
            rd_data1 = '0;
            rd_busy1 = 1'b0;
        end
    end

    // Read port 2
    always_comb begin
        rd_data2 = regs_q[rd_addr2];
        rd_busy2 = busy_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            if (!rst) begin
                rd_busy2 = 1'b0;
            end
        end
`endif
        if (is_zero(rd_addr2)) begin
            rd_data2 = '0;
            rd_busy2 = 1'b0;
        end
    end

endmodule
